// File: rtl/calc_alu_seq.sv
// ---------------------------------------------------------------------------
// calc_alu_seq
//   Multi-cycle arithmetic sequencer between the calculator controller and
//   the arithmetic datapath. Add/subtract take one execute step; multiply is
//   an iterative shift-add over WIDTH steps. One extra EXEC cycle finalises
//   the result before the DONE cycle.
//
// Ports
//   clk        rising-edge system clock
//   nRST       asynchronous active-low reset
//   start      request strobe, sampled only in IDLE
//   op         one-hot operator: 001 add, 010 subtract (a-b), 100 multiply
//   operand_a  signed left operand  (WIDTH bits)
//   operand_b  signed right operand (WIDTH bits)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse, result/flags valid
//   result     signed result, held until the next completion
//   overflow   true result not representable in WIDTH signed bits
//   error      op was not exactly one-hot
//
// Build option
//   CALC_ALU_SATURATE_EN : saturate result on overflow instead of wrapping.
// ---------------------------------------------------------------------------
module calc_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             error
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   mcand;     // |a|
    logic [2*WIDTH-1:0] acc;       // upper half: partial sum, lower half: multiplier
    logic               sign_r;
    logic [CW-1:0]      cnt;
    logic               fin;       // arithmetic complete, next EXEC edge finalises

    logic               op_add, op_sub, op_mul;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     addsub;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_ovf, fin_err, fin_neg;

    assign op_add = (op_r == 3'b001);
    assign op_sub = (op_r == 3'b010);
    assign op_mul = (op_r == 3'b100);

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct as unsigned
    assign abs_a = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

    assign addsub = op_sub ? ({a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r})
                           : ({a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r});

    // carry out of the upper-half add shifts into the accumulator MSB
    assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};

    assign prod = sign_r ? (~acc + (2*WIDTH)'(1)) : acc;

`ifdef CALC_ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_err = 1'b0;
        fin_neg = 1'b0;
        if (op_mul) begin
            // representable only if the top WIDTH+1 bits are a pure sign extension
            fin_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
            fin_res = prod[WIDTH-1:0];
            fin_neg = prod[2*WIDTH-1];
        end else if (op_add || op_sub) begin
            fin_ovf = acc[WIDTH] ^ acc[WIDTH-1];
            fin_res = acc[WIDTH-1:0];
            fin_neg = acc[WIDTH];
        end else begin
            fin_err = 1'b1;
        end
`ifdef CALC_ALU_SATURATE_EN
        if (fin_ovf)
            fin_res = fin_neg ? SAT_MIN : SAT_MAX;
`endif
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            mcand    <= '0;
            acc      <= '0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            fin      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= operand_a;
                        b_r      <= operand_b;
                        op_r     <= op;
                        mcand    <= abs_a;
                        acc      <= {{WIDTH{1'b0}}, abs_b};
                        sign_r   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        cnt      <= '0;
                        fin      <= 1'b0;
                        overflow <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (fin) begin
                        result   <= fin_res;
                        overflow <= fin_ovf;
                        error    <= fin_err;
                        done     <= 1'b1;
                        fin      <= 1'b0;
                        state    <= DONE;
                    end else if (op_mul) begin
                        acc <= acc[0] ? {psum, acc[WIDTH-1:1]}
                                      : {1'b0, acc[2*WIDTH-1:1]};
                        if (cnt == CW'(WIDTH-1))
                            fin <= 1'b1;
                        else
                            cnt <= cnt + CW'(1);
                    end else if (op_add || op_sub) begin
                        acc <= {{(WIDTH-1){1'b0}}, addsub};
                        fin <= 1'b1;
                    end else begin
                        fin <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
